cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 155 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB.
// Optional retired-instruction counter enabled by SEQ_PERF_CNT_EN.
module cpu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       op,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             m2reg,
    output logic             pc_we,
    output logic             busy,
    output logic [1:0]       pc_src,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        FETCH  = 3'b001,
        DECODE = 3'b010,
        EXEC   = 3'b011,
        MEM    = 3'b100,
        WB     = 3'b101
    } state_t;

    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_REL = 2'b01;
    localparam logic [1:0] SRC_REG = 2'b10;

    state_t cur;
    state_t nxt;
    logic   retire;

    logic is_branch;
    logic is_mem;
    logic is_load;
    logic is_store;

    assign is_branch = (op[3:1] == 3'b001);
    assign is_mem    = (op[3:2] == 2'b01);
    assign is_load   = is_mem & ~op[1];
    assign is_store  = is_mem & op[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt      = cur;
        retire   = 1'b0;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        m2reg    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = SRC_SEQ;
        case (cur)
            IDLE: begin
                if (run) begin
                    nxt = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we = 1'b1;
                    nxt   = DECODE;
                end
            end
            DECODE: begin
                nxt = EXEC;
            end
            EXEC: begin
                unique case (1'b1)
                    is_branch: begin
                        pc_we  = 1'b1;
                        pc_src = zero ? SRC_SEQ : SRC_REL;
                        retire = 1'b1;
                    end
                    is_mem: begin
                        nxt = MEM;
                    end
                    default: begin
                        nxt = WB;
                    end
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = op[1];
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        nxt = WB;
                    end
                end
            end
            WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                m2reg  = is_load;
                retire = 1'b1;
                unique case (1'b1)
                    (op == 4'b0000): pc_src = SRC_REL;
                    (op == 4'b0001): pc_src = SRC_REG;
                    default:         pc_src = SRC_SEQ;
                endcase
            end
            default: begin
                nxt = IDLE;
            end
        endcase
        // A retiring instruction always completes; run only picks what follows.
        if (retire) begin
            nxt = run ? FETCH : IDLE;
        end
    end

    assign busy  = (cur != IDLE);
    assign state = cur;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign instr_cnt = cnt_q;
`else
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-cycle vector table
// through an expectation queue, plus reset and counter sequences.
module tb_cpu_sequencer;

    localparam int CW = 4;

    localparam logic [2:0] ID = 3'b000;
    localparam logic [2:0] FE = 3'b001;
    localparam logic [2:0] DE = 3'b010;
    localparam logic [2:0] EX = 3'b011;
    localparam logic [2:0] ME = 3'b100;
    localparam logic [2:0] WB = 3'b101;

    // strobe order: imem_req ir_we dmem_req dmem_we reg_we m2reg pc_we
    localparam logic [6:0] S_IM = 7'b1000000;
    localparam logic [6:0] S_IR = 7'b0100000;
    localparam logic [6:0] S_DQ = 7'b0010000;
    localparam logic [6:0] S_DW = 7'b0001000;
    localparam logic [6:0] S_RW = 7'b0000100;
    localparam logic [6:0] S_M2 = 7'b0000010;
    localparam logic [6:0] S_PW = 7'b0000001;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [3:0]    op;
    logic          zero;
    logic          imem_ready;
    logic          dmem_ready;
    logic          imem_req;
    logic          ir_we;
    logic          dmem_req;
    logic          dmem_we;
    logic          reg_we;
    logic          m2reg;
    logic          pc_we;
    logic          busy;
    logic [1:0]    pc_src;
    logic [2:0]    state;
    logic [CW-1:0] instr_cnt;

    always #5 clk = ~clk;

    cpu_sequencer #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .op         (op),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_we      (ir_we),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .reg_we     (reg_we),
        .m2reg      (m2reg),
        .pc_we      (pc_we),
        .busy       (busy),
        .pc_src     (pc_src),
        .state      (state),
        .instr_cnt  (instr_cnt)
    );

    typedef struct {
        logic        r;
        logic [3:0]  o;
        logic        z;
        logic        ir;
        logic        dr;
        logic [12:0] x;
    } vec_t;

    vec_t        tbl[$];
    logic [12:0] exp_q[$];
    int          passed = 0;
    int          total = 0;
    int          nret = 0;

    function automatic logic [12:0] e(input logic [2:0] st,
                                      input logic [6:0] s,
                                      input logic [1:0] src);
        return {st, s, src, (st != ID)};
    endfunction

    function automatic logic [12:0] act();
        return {state, imem_req, ir_we, dmem_req, dmem_we,
                reg_we, m2reg, pc_we, pc_src, busy};
    endfunction

    task automatic chk(input string name, input logic [12:0] x);
        logic [12:0] a;
        a = act();
        total++;
        if (a !== x) begin
            $display("FAIL %s: got st/strb/src/busy=%b want %b",
                     name, a, x);
        end else begin
            passed++;
        end
    endtask

    task automatic chk_cnt(input string name, input int x);
        total++;
        if (instr_cnt !== CW'(x)) begin
            $display("FAIL %s: instr_cnt got %0d want %0d",
                     name, instr_cnt, CW'(x));
        end else begin
            passed++;
        end
    endtask

    function automatic int cnt_exp(input int n);
`ifdef SEQ_PERF_CNT_EN
        return n % (1 << CW);
`else
        return 0 * n;
`endif
    endfunction

    task automatic add(input logic r, input logic [3:0] o,
                       input logic z, input logic ir,
                       input logic dr, input logic [12:0] x);
        tbl.push_back('{r, o, z, ir, dr, x});
    endtask

    // op is inverted during FETCH/DECODE: it must be ignored there
    task automatic fd(input logic [3:0] o, input int iw);
        repeat (iw) add(1'b1, ~o, 1'b0, 1'b0, 1'b1, e(FE, S_IM, 2'b00));
        add(1'b1, ~o, 1'b0, 1'b1, 1'b1, e(FE, S_IM | S_IR, 2'b00));
        add(1'b1, ~o, 1'b1, 1'b1, 1'b1, e(DE, 7'b0, 2'b00));
    endtask

    task automatic alu(input logic [3:0] o, input logic [1:0] src,
                       input logic r, input int iw);
        fd(o, iw);
        add(1'b1, o, 1'b0, 1'b1, 1'b1, e(EX, 7'b0, 2'b00));
        add(r, o, 1'b0, 1'b1, 1'b1, e(WB, S_RW | S_PW, src));
        nret++;
    endtask

    task automatic br(input logic [3:0] o, input logic z);
        fd(o, 0);
        add(1'b1, o, z, 1'b1, 1'b1,
            e(EX, S_PW, z ? 2'b00 : 2'b01));
        nret++;
    endtask

    task automatic ld(input logic [3:0] o, input int dw);
        fd(o, 0);
        add(1'b1, o, 1'b0, 1'b1, 1'b0, e(EX, 7'b0, 2'b00));
        repeat (dw) add(1'b1, o, 1'b0, 1'b1, 1'b0, e(ME, S_DQ, 2'b00));
        add(1'b1, o, 1'b0, 1'b1, 1'b1, e(ME, S_DQ, 2'b00));
        add(1'b1, o, 1'b0, 1'b1, 1'b1,
            e(WB, S_RW | S_M2 | S_PW, 2'b00));
        nret++;
    endtask

    task automatic st(input logic [3:0] o);
        fd(o, 0);
        add(1'b1, o, 1'b0, 1'b1, 1'b1, e(EX, 7'b0, 2'b00));
        add(1'b1, o, 1'b0, 1'b1, 1'b1,
            e(ME, S_DQ | S_DW | S_PW, 2'b00));
        nret++;
    endtask

    initial begin
        rst        = 1'b1;
        run        = 1'b0;
        op         = 4'h0;
        zero       = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #2;
        chk("reset_state", e(ID, 7'b0, 2'b00));
        chk_cnt("reset_cnt", 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        add(1'b1, 4'h8, 1'b0, 1'b1, 1'b1, e(ID, 7'b0, 2'b00));
        alu(4'h8, 2'b00, 1'b1, 0);
        br(4'h2, 1'b0);
        br(4'h2, 1'b1);
        ld(4'h5, 3);
        st(4'h7);
        alu(4'h1, 2'b10, 1'b1, 0);
        alu(4'h0, 2'b01, 1'b1, 0);
        ld(4'h4, 0);
        st(4'h6);
        br(4'h3, 1'b0);
        alu(4'hC, 2'b00, 1'b1, 2);
        alu(4'hA, 2'b00, 1'b0, 0);
        add(1'b0, 4'h8, 1'b0, 1'b1, 1'b1, e(ID, 7'b0, 2'b00));
        add(1'b0, 4'h8, 1'b0, 1'b1, 1'b1, e(ID, 7'b0, 2'b00));

        foreach (tbl[i]) begin
            run        = tbl[i].r;
            op         = tbl[i].o;
            zero       = tbl[i].z;
            imem_ready = tbl[i].ir;
            dmem_ready = tbl[i].dr;
            exp_q.push_back(tbl[i].x);
            @(negedge clk);
            chk($sformatf("vec%0d", i), exp_q.pop_front());
            @(posedge clk);
            #1;
        end
        chk_cnt("table_cnt", cnt_exp(nret));

        // reset while stalled in MEM, no clock edge in between
        run        = 1'b1;
        op         = 4'h5;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mem_before_rst", e(ME, S_DQ, 2'b00));
        rst = 1'b1;
        #1;
        chk("rst_in_mem", e(ID, 7'b0, 2'b00));
        chk_cnt("rst_in_mem_cnt", 0);
        run = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_run0", e(ID, 7'b0, 2'b00));
        run  = 1'b1;
        op   = 4'h2;
        zero = 1'b1;
        dmem_ready = 1'b1;
        #1;
        chk("idle_run1", e(ID, 7'b0, 2'b00));
        @(posedge clk);
        #1;
        chk("first_fetch", e(FE, S_IM | S_IR, 2'b00));

        // 16 branches wrap the 4-bit counter, the 17th leaves it at 1
        repeat (48) @(posedge clk);
        #1;
        chk("wrap_state", e(FE, S_IM | S_IR, 2'b00));
        chk_cnt("cnt_16", cnt_exp(16));
        repeat (3) @(posedge clk);
        #1;
        chk_cnt("cnt_17", cnt_exp(17));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
